// File: rtl/noc_local_ni.sv
// noc_local_ni: network interface on a router's Local port (TX injector + RX ejector).
// Define NI_STATS_EN to build the tx/rx/drop counters and max-latency tracker.
module noc_local_ni #(
  parameter logic [3:0] NODE_ID  = 4'd0,
  parameter int         DEPTH    = 8,
  parameter int         WIDTH    = 3,
  parameter int         DATASIZE = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                core_tx_valid,
  output logic                core_tx_ready,
  input  logic [3:0]          core_tx_dst,
  input  logic [21:0]         core_tx_data,
  input  logic [1:0]          core_tx_type,
  output logic [DATASIZE-1:0] ni_data_out,
  output logic                ni_valid_out,
  input  logic                router_full,
  input  logic [DATASIZE-1:0] router_data_in,
  input  logic                router_valid_in,
  output logic                core_rx_valid,
  input  logic                core_rx_ready,
  output logic [3:0]          core_rx_src,
  output logic [21:0]         core_rx_data,
  output logic [1:0]          core_rx_type,
  output logic [7:0]          core_rx_latency,
  output logic                misroute_err,
  output logic [15:0]         tx_count,
  output logic [15:0]         rx_count,
  output logic [15:0]         drop_count,
  output logic [7:0]          max_latency
);

  localparam int TXW = 28;
  localparam int RXW = 36;
  localparam logic [WIDTH:0] FULL_CNT = (WIDTH+1)'(DEPTH);

  logic [7:0] ts_cnt_q;

  // ---------------- TX path ----------------
  logic [TXW-1:0]   tx_mem [DEPTH];
  logic [WIDTH-1:0] tx_wr_q, tx_rd_q;
  logic [WIDTH:0]   tx_cnt_q;
  logic             tx_full, tx_empty, tx_push, tx_pop;
  logic [TXW-1:0]   tx_head;

  assign tx_full       = (tx_cnt_q == FULL_CNT);
  assign tx_empty      = (tx_cnt_q == '0);
  assign tx_push       = core_tx_valid & ~tx_full;
  assign tx_pop        = ~tx_empty & ~router_full;
  assign tx_head       = tx_mem[tx_rd_q];
  assign core_tx_ready = ~tx_full;
  assign ni_valid_out  = tx_pop;

  // Timestamp is taken at injection, so the flit carries network-only latency.
  assign ni_data_out = tx_pop ? DATASIZE'({NODE_ID, tx_head[27:24], ts_cnt_q,
                                           tx_head[23:2], tx_head[1:0]})
                              : '0;

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_q] <= {core_tx_dst, core_tx_data, core_tx_type};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      ts_cnt_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 8'd1;
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
        2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic [RXW-1:0]   rx_mem [DEPTH];
  logic [WIDTH-1:0] rx_wr_q, rx_rd_q;
  logic [WIDTH:0]   rx_cnt_q;
  logic             rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]       rx_lat;
  logic [RXW-1:0]   rx_head;
  logic             misroute_q;

  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_pop   = ~rx_empty & core_rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign rx_push  = router_valid_in & (~rx_full | rx_pop);
  assign rx_lat   = ts_cnt_q - router_data_in[31:24];
  assign rx_head  = rx_mem[rx_rd_q];

  assign core_rx_valid   = ~rx_empty;
  assign core_rx_src     = rx_empty ? 4'd0  : rx_head[35:32];
  assign core_rx_data    = rx_empty ? 22'd0 : rx_head[31:10];
  assign core_rx_type    = rx_empty ? 2'd0  : rx_head[9:8];
  assign core_rx_latency = rx_empty ? 8'd0  : rx_head[7:0];
  assign misroute_err    = misroute_q;

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_q] <= {router_data_in[39:36], router_data_in[23:2],
                          router_data_in[1:0], rx_lat};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      misroute_q <= 1'b0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
        2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
        default: rx_cnt_q <= rx_cnt_q;
      endcase
      if (router_valid_in && (router_data_in[35:32] != NODE_ID)) begin
        misroute_q <= 1'b1;
      end
    end
  end

  // ---------------- Statistics ----------------
`ifdef NI_STATS_EN
  logic        rx_drop;
  logic [15:0] tx_count_q, rx_count_q, drop_count_q;
  logic [7:0]  max_lat_q;

  assign rx_drop = router_valid_in & ~rx_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_count_q   <= '0;
      rx_count_q   <= '0;
      drop_count_q <= '0;
      max_lat_q    <= '0;
    end else begin
      if (tx_pop && (tx_count_q != 16'hFFFF))    tx_count_q   <= tx_count_q + 16'd1;
      if (rx_push && (rx_count_q != 16'hFFFF))   rx_count_q   <= rx_count_q + 16'd1;
      if (rx_drop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
      if (rx_push && (rx_lat > max_lat_q))       max_lat_q    <= rx_lat;
    end
  end

  assign tx_count    = tx_count_q;
  assign rx_count    = rx_count_q;
  assign drop_count  = drop_count_q;
  assign max_latency = max_lat_q;
`else
  assign tx_count    = '0;
  assign rx_count    = '0;
  assign drop_count  = '0;
  assign max_latency = '0;
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// tb_noc_local_ni: randomized + directed bench for noc_local_ni against a queue-based reference model.
// Stats checks follow the NI_STATS_EN macro the bench is built with.
module tb_noc_local_ni;
  localparam logic [3:0] NID = 4'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_tx_valid, core_tx_ready;
  logic [3:0]  core_tx_dst;
  logic [21:0] core_tx_data;
  logic [1:0]  core_tx_type;
  logic [39:0] ni_data_out;
  logic        ni_valid_out, router_full;
  logic [39:0] router_data_in;
  logic        router_valid_in, core_rx_valid, core_rx_ready;
  logic [3:0]  core_rx_src;
  logic [21:0] core_rx_data;
  logic [1:0]  core_rx_type;
  logic [7:0]  core_rx_latency, max_latency;
  logic        misroute_err;
  logic [15:0] tx_count, rx_count, drop_count;

  noc_local_ni #(.NODE_ID(NID), .DEPTH(8), .WIDTH(3), .DATASIZE(40)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_tx_valid(core_tx_valid), .core_tx_ready(core_tx_ready),
    .core_tx_dst(core_tx_dst), .core_tx_data(core_tx_data), .core_tx_type(core_tx_type),
    .ni_data_out(ni_data_out), .ni_valid_out(ni_valid_out), .router_full(router_full),
    .router_data_in(router_data_in), .router_valid_in(router_valid_in),
    .core_rx_valid(core_rx_valid), .core_rx_ready(core_rx_ready),
    .core_rx_src(core_rx_src), .core_rx_data(core_rx_data), .core_rx_type(core_rx_type),
    .core_rx_latency(core_rx_latency), .misroute_err(misroute_err),
    .tx_count(tx_count), .rx_count(rx_count), .drop_count(drop_count),
    .max_latency(max_latency)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [3:0] dst; logic [21:0] data; logic [1:0] typ;} tx_ent_t;
  typedef struct packed {logic [3:0] src; logic [21:0] data; logic [1:0] typ; logic [7:0] lat;} rx_ent_t;

  tx_ent_t    tx_q[$];
  rx_ent_t    rx_q[$];
  logic [7:0] m_ts;
  bit         m_mis;
  int         m_txc, m_rxc, m_drop;
  logic [7:0] m_maxlat;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_ts = 8'd0; m_mis = 1'b0;
    m_txc = 0; m_rxc = 0; m_drop = 0; m_maxlat = 8'd0;
  endtask

  function automatic logic [39:0] mk_flit(input logic [3:0] s, input logic [3:0] d,
                                         input logic [7:0] t, input logic [21:0] p,
                                         input logic [1:0] ty);
    return {s, d, t, p, ty};
  endfunction

  task automatic check_outputs();
    logic        exp_nv;
    logic [39:0] exp_nd;
    rx_ent_t     h;
    exp_nv = (tx_q.size() != 0) && !router_full;
    exp_nd = '0;
    if (exp_nv) exp_nd = {NID, tx_q[0].dst, m_ts, tx_q[0].data, tx_q[0].typ};
    h = '0;
    if (rx_q.size() != 0) h = rx_q[0];
    check_eq("core_tx_ready", 40'(core_tx_ready), 40'(tx_q.size() < 8));
    check_eq("ni_valid_out", 40'(ni_valid_out), 40'(exp_nv));
    check_eq("ni_data_out", ni_data_out, exp_nd);
    check_eq("core_rx_valid", 40'(core_rx_valid), 40'(rx_q.size() != 0));
    check_eq("core_rx_src", 40'(core_rx_src), 40'(h.src));
    check_eq("core_rx_data", 40'(core_rx_data), 40'(h.data));
    check_eq("core_rx_type", 40'(core_rx_type), 40'(h.typ));
    check_eq("core_rx_latency", 40'(core_rx_latency), 40'(h.lat));
    check_eq("misroute_err", 40'(misroute_err), 40'(m_mis));
`ifdef NI_STATS_EN
    check_eq("tx_count", 40'(tx_count), 40'(m_txc));
    check_eq("rx_count", 40'(rx_count), 40'(m_rxc));
    check_eq("drop_count", 40'(drop_count), 40'(m_drop));
    check_eq("max_latency", 40'(max_latency), 40'(m_maxlat));
`else
    check_eq("stats_zero", 40'({tx_count, rx_count, drop_count, max_latency}), 40'd0);
`endif
  endtask

  task automatic update_model();
    bit         pop_tx, push_tx, pop_rx, acc;
    tx_ent_t    te;
    rx_ent_t    re;
    pop_tx  = (tx_q.size() != 0) && !router_full;
    push_tx = core_tx_valid && (tx_q.size() < 8);
    pop_rx  = (rx_q.size() != 0) && core_rx_ready;
    acc     = (rx_q.size() < 8) || pop_rx;
    if (pop_tx) begin
      tx_q.delete(0);
      if (m_txc < 65535) m_txc++;
    end
    if (push_tx) begin
      te = {core_tx_dst, core_tx_data, core_tx_type};
      tx_q.push_back(te);
    end
    if (pop_rx) rx_q.delete(0);
    if (router_valid_in) begin
      if (router_data_in[35:32] != NID) m_mis = 1'b1;
      if (acc) begin
        re = {router_data_in[39:36], router_data_in[23:2], router_data_in[1:0],
              8'(m_ts - router_data_in[31:24])};
        rx_q.push_back(re);
        if (m_rxc < 65535) m_rxc++;
        if (re.lat > m_maxlat) m_maxlat = re.lat;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    m_ts = m_ts + 8'd1;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    core_tx_valid   = 1'b0;
    core_tx_dst     = 4'($urandom);
    core_tx_data    = 22'($urandom);
    core_tx_type    = 2'($urandom);
    router_full     = 1'b0;
    router_valid_in = 1'b0;
    router_data_in  = 40'd0;
    core_rx_ready   = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check_eq("reset_tx_ready", 40'(core_tx_ready), 40'd1);
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Reset mid-traffic with three flits queued behind a full router
    router_full = 1'b1;
    core_tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      core_tx_dst = 4'($urandom); core_tx_data = 22'($urandom); core_tx_type = 2'($urandom);
      step();
    end
    set_idle();
    router_full = 1'b1;
    do_reset();
    set_idle();

    // First push after reset: injected next cycle, stamped with ts 1
    core_tx_valid = 1'b1; core_tx_dst = 4'h9; core_tx_data = 22'h012345; core_tx_type = 2'b10;
    step();
    core_tx_valid = 1'b0;
    #1;
    check_eq("t2_valid", 40'(ni_valid_out), 40'd1);
    check_eq("t2_flit", ni_data_out, {4'h5, 4'h9, 8'h01, 22'h012345, 2'b10});
    step();

    // Fill TX behind backpressure, then drain back-to-back
    router_full = 1'b1;
    core_tx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      core_tx_dst = 4'($urandom); core_tx_data = 22'($urandom); core_tx_type = 2'($urandom);
      step();
    end
    #1;
    check_eq("t3_ready_full", 40'(core_tx_ready), 40'd0);
    check_eq("t3_no_inject", 40'(ni_valid_out), 40'd0);
    step();
    core_tx_valid = 1'b0;
    router_full = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (ni_valid_out) cnt++;
      step();
    end
    check_eq("t3_burst_len", 40'(cnt), 40'd8);
    check_eq("t3_drained", 40'(ni_valid_out), 40'd0);

    // Latency across timestamp wrap: ts F0 arrives at ts_cnt 05
    set_idle();
    for (int i = 0; i < 300 && m_ts != 8'h05; i++) step();
    check_eq("t4_ts_align", 40'(m_ts), 40'h05);
    router_valid_in = 1'b1;
    router_data_in = mk_flit(4'h2, NID, 8'hF0, 22'($urandom), 2'b01);
    core_rx_ready = 1'b0;
    step();
    router_valid_in = 1'b0;
    #1;
    check_eq("t4_rx_valid", 40'(core_rx_valid), 40'd1);
    check_eq("t4_latency", 40'(core_rx_latency), 40'h15);
`ifdef NI_STATS_EN
    check_eq("t4_max_latency", 40'(max_latency), 40'h15);
`endif
    core_rx_ready = 1'b1;
    step();

    // RX overflow: 9 arrivals with no pop, then full + pop + arrival
    core_rx_ready = 1'b0;
    router_valid_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      router_data_in = mk_flit(4'($urandom), NID, m_ts - 8'(i), 22'($urandom), 2'($urandom));
      step();
    end
    router_valid_in = 1'b0;
    #1;
    check_eq("t5_rx_full_valid", 40'(core_rx_valid), 40'd1);
`ifdef NI_STATS_EN
    check_eq("t5_drop_one", 40'(drop_count), 40'd1);
`endif
    core_rx_ready = 1'b1;
    router_valid_in = 1'b1;
    router_data_in = mk_flit(4'hA, NID, m_ts, 22'h3ABCDE, 2'b11);
    step();
    router_valid_in = 1'b0;
    core_rx_ready = 1'b0;
    #1;
    check_eq("t5_queue_size", 40'(rx_q.size()), 40'd8);
`ifdef NI_STATS_EN
    check_eq("t5_drop_still_one", 40'(drop_count), 40'd1);
`endif
    core_rx_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();

    // Misrouted flit: delivered with src intact, error sticks
    router_valid_in = 1'b1;
    router_data_in = mk_flit(4'h7, 4'h3, m_ts, 22'h155555, 2'b00);
    core_rx_ready = 1'b0;
    step();
    router_valid_in = 1'b0;
    #1;
    check_eq("t6_src", 40'(core_rx_src), 40'h7);
    check_eq("t6_misroute", 40'(misroute_err), 40'd1);
    for (int i = 0; i < 100; i++) begin
      core_rx_ready   = 1'($urandom);
      router_valid_in = 1'($urandom);
      router_data_in  = mk_flit(4'($urandom), NID, m_ts - 8'($urandom_range(0, 40)),
                                22'($urandom), 2'($urandom));
      core_tx_valid   = 1'($urandom);
      core_tx_dst     = 4'($urandom); core_tx_data = 22'($urandom); core_tx_type = 2'($urandom);
      step();
    end
    #1;
    check_eq("t6_misroute_held", 40'(misroute_err), 40'd1);

    // Randomized traffic with varying pressure on both sides
    set_idle();
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      int p_full, p_ready, p_rv;
      p_full  = $urandom_range(0, 80);
      p_ready = $urandom_range(10, 100);
      p_rv    = $urandom_range(20, 90);
      for (int i = 0; i < 300; i++) begin
        core_tx_valid   = ($urandom_range(0, 99) < 60);
        core_tx_dst     = 4'($urandom); core_tx_data = 22'($urandom); core_tx_type = 2'($urandom);
        router_full     = ($urandom_range(0, 99) < p_full);
        core_rx_ready   = ($urandom_range(0, 99) < p_ready);
        router_valid_in = ($urandom_range(0, 99) < p_rv);
        router_data_in  = mk_flit(4'($urandom),
                                  ($urandom_range(0, 99) < 97) ? NID : 4'($urandom),
                                  8'($urandom), 22'($urandom), 2'($urandom));
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
